// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the ECDSA modular-arithmetic blocks.
package ecdsa_pkg;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    IDLE, SCAN, TOX, TOONE, SQR, MUL, NEXT, FROM, DONE
  } modexp_state_t;

  typedef enum logic {LAUNCH, WAIT} mm_phase_t;

  // Operand pair presented to the multiplier, as (mm_a, mm_b)
  typedef enum logic [2:0] {
    SEL_X_R2, SEL_ONE_R2, SEL_ACC_ACC, SEL_ACC_XM, SEL_ACC_ONE
  } mm_sel_t;

  function automatic mm_sel_t mm_sel_of(input modexp_state_t st);
    case (st)
      TOX:     return SEL_X_R2;
      TOONE:   return SEL_ONE_R2;
      SQR:     return SEL_ACC_ACC;
      MUL:     return SEL_ACC_XM;
      default: return SEL_ACC_ONE;
    endcase
  endfunction

endpackage

// File: rtl/mont_modexp.sv
// y = x^e mod n by left-to-right square-and-multiply in the Montgomery
// domain, sequencing an external multiplier over a start/done port.
module mont_modexp #(
  parameter int unsigned WIDTH = ecdsa_pkg::WIDTH,
  parameter int unsigned CNT_W = ecdsa_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic [WIDTH-1:0] mm_c,
  input  logic             mm_done
);
  import ecdsa_pkg::*;

  modexp_state_t    state_q, state_d;
  mm_phase_t        phase_q, phase_d;
  logic [WIDTH-1:0] x_q, x_d, e_q, e_d, r2_q, r2_d;
  logic [WIDTH-1:0] xm_q, xm_d, acc_q, acc_d, y_q, y_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             ezero_q, ezero_d, busy_q, busy_d, done_q, done_d;
  logic             mm_start_q, mm_start_d;
  logic [WIDTH-1:0] op_a, op_b;

  // The modulus lives in the multiplier; it is carried here only for wiring.
  logic unused_n;
  assign unused_n = ^n;

  // Operand mux for the multiplier call owned by the current state
  always_comb begin
    op_a = acc_q;
    op_b = WIDTH'(1);
    case (mm_sel_of(state_q))
      SEL_X_R2:    begin op_a = x_q;       op_b = r2_q; end
      SEL_ONE_R2:  begin op_a = WIDTH'(1); op_b = r2_q; end
      SEL_ACC_ACC: op_b = acc_q;
      SEL_ACC_XM:  op_b = xm_q;
      default:     ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    x_d        = x_q;
    e_d        = e_q;
    r2_d       = r2_q;
    xm_d       = xm_q;
    acc_d      = acc_q;
    y_d        = y_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    idx_d      = idx_q;
    ezero_d    = ezero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mm_start_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x_d     = x;
        e_d     = e;
        r2_d    = r2;
        idx_d   = CNT_W'(WIDTH - 1);
        ezero_d = 1'b0;
        busy_d  = 1'b1;
        phase_d = LAUNCH;
        state_d = SCAN;
      end
      // Skip leading zeros; an all-zero exponent runs out of index first
      SCAN: if (e_q[WIDTH-1] || idx_q == '0) begin
        ezero_d = ~e_q[WIDTH-1];
        state_d = TOX;
      end else begin
        e_d   = e_q << 1;
        idx_d = idx_q - CNT_W'(1);
      end
      TOX, TOONE, SQR, MUL, FROM: begin
        if (phase_q == LAUNCH) begin
          mm_a_d     = op_a;
          mm_b_d     = op_b;
          mm_start_d = 1'b1;
          phase_d    = WAIT;
        end else if (mm_done) begin
          phase_d = LAUNCH;
          case (state_q)
            TOX:     begin xm_d  = mm_c; state_d = TOONE; end
            TOONE:   begin acc_d = mm_c; state_d = ezero_q ? FROM : SQR; end
            SQR:     begin acc_d = mm_c; state_d = e_q[WIDTH-1] ? MUL : NEXT; end
            MUL:     begin acc_d = mm_c; state_d = NEXT; end
            default: begin
              y_d     = mm_c;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          endcase
        end
      end
      NEXT: if (idx_q == '0) begin
        state_d = FROM;
      end else begin
        e_d     = e_q << 1;
        idx_d   = idx_q - CNT_W'(1);
        state_d = SQR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= LAUNCH;
      x_q        <= '0;
      e_q        <= '0;
      r2_q       <= '0;
      xm_q       <= '0;
      acc_q      <= '0;
      y_q        <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      idx_q      <= '0;
      ezero_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      x_q        <= x_d;
      e_q        <= e_d;
      r2_q       <= r2_d;
      xm_q       <= xm_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      idx_q      <= idx_d;
      ezero_q    <= ezero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign y        = y_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;

endmodule

// File: tb/tb_mont_modexp.sv
// Bench for mont_modexp: behavioural Montgomery multiplier, scoreboard on y.
module tb_mont_modexp;

  localparam int unsigned N      = 10000019;
  localparam int unsigned XB     = 357588;
  localparam int          RUN_TO = 6000;
  localparam int          N_RAND = 16;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [255:0] x_i, e_i, n_i, r2_i;
  logic         busy, done, mm_start, mm_done;
  logic [255:0] y, mm_a, mm_b, mm_c;

  int n_chk = 0;
  int n_bad = 0;
  int lat   = 1;
  logic [255:0] exp_q[$];

  mont_modexp dut (
    .clk(clk), .reset(reset), .start(start), .x(x_i), .e(e_i), .n(n_i),
    .r2(r2_i), .busy(busy), .done(done), .y(y), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // MM(a,b) = a*b*2^-256 mod N by bitwise reduction
  function automatic logic [255:0] mont(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] am, bm;
    longint unsigned t;
    am = a % 256'(N);
    bm = b % 256'(N);
    t  = am[63:0] * bm[63:0];
    for (int i = 0; i < 256; i++) begin
      if (t[0]) t = t + 64'(N);
      t = t >> 1;
    end
    return 256'(t % 64'(N));
  endfunction

  // Plain integer pow-mod, independent of the Montgomery formulation
  function automatic logic [255:0] powmod(input logic [255:0] b, input logic [255:0] ex);
    longint unsigned r, bb;
    logic [255:0] bm;
    bm = b % 256'(N);
    bb = bm[63:0];
    r  = 64'd1 % 64'(N);
    for (int i = 255; i >= 0; i--) begin
      r = (r * r) % 64'(N);
      if (ex[i]) r = (r * bb) % 64'(N);
    end
    return 256'(r);
  endfunction

  function automatic int exp_calls(input logic [255:0] ex);
    int b;
    b = -1;
    for (int i = 0; i < 256; i++) if (ex[i]) b = i;
    return (b < 0) ? 3 : 3 + (b + 1) + $countones(ex);
  endfunction

  // Behavioural multiplier: mm_done pulses lat cycles after mm_start
  logic         mm_pend = 1'b0;
  int           mm_cnt  = 0;
  logic [255:0] mm_res  = '0;
  always @(negedge clk) begin
    mm_done = 1'b0;
    if (mm_pend) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mm_done = 1'b1;
        mm_c    = mm_res;
        mm_pend = 1'b0;
      end
    end
    if (mm_start) begin
      mm_pend = 1'b1;
      mm_cnt  = lat;
      mm_res  = mont(mm_a, mm_b);
    end
  end

  // Scoreboard and done-pulse shape
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse", 256'(prev_done), 256'd0);
      chk("done_busy", 256'(busy), 256'd0);
      chk("sb_nonempty", 256'(exp_q.size() != 0), 256'd1);
      if (exp_q.size() != 0) chk("y_sb", y, exp_q.pop_front());
    end
    prev_done = done;
  end

  task automatic run(input logic [255:0] xv, input logic [255:0] ev, input int poke_at,
                     input int abort_at, output int calls, output int first_lat,
                     output logic [255:0] yv);
    int cyc;
    bit poked;
    exp_q.push_back(powmod(xv, ev));
    x_i   = xv;
    e_i   = ev;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 256'(busy), 256'd1);
    calls = 0; first_lat = -1; cyc = 0; poked = 0; yv = '0;
    while (!done && cyc < RUN_TO) begin
      start = 1'b0;
      if (mm_start) begin
        calls++;
        if (first_lat < 0) first_lat = cyc;
      end
      if (poke_at > 0 && calls == poke_at && !poked) begin
        start = 1'b1;
        x_i   = 256'd1;
        e_i   = 256'd5;
        poked = 1;
      end
      if (abort_at > 0 && calls == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_done", 256'(done), 256'd0);
        chk("abort_y", y, 256'd0);
        chk("abort_mm_start", 256'(mm_start), 256'd0);
        chk("abort_mm_a", mm_a, 256'd0);
        chk("abort_mm_b", mm_b, 256'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("run_done", 256'(done), 256'd1);
    yv = y;
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog busy=%0b done=%0b", busy, done);
    $fatal(1, "watchdog");
  end

  initial begin
    int calls, l3, l0, lbig, late;
    logic [255:0] yv, ev, xv, v;
    reset = 1'b1; start = 1'b0; x_i = '0; e_i = '0;
    mm_done = 1'b0; mm_c = '0;
    n_i = 256'(N);
    v = 256'd1;
    for (int i = 0; i < 512; i++) v = (v << 1) % 256'(N);
    r2_i = v;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_y", y, 256'd0);
    chk("rst_mm_start", 256'(mm_start), 256'd0);
    chk("rst_mm_a", mm_a, 256'd0);
    chk("rst_mm_b", mm_b, 256'd0);
    reset = 1'b0;
    @(negedge clk);

    lat = 1;
    run(256'(XB), 256'd3, 0, 0, calls, l3, yv);
    chk("y_e3", yv, 256'd4767837);
    chk("calls_e3", 256'(calls), 256'd7);
    run(256'(XB), 256'd2, 0, 0, calls, late, yv);
    chk("y_e2", yv, 256'd8934810);
    chk("calls_e2", 256'(calls), 256'(exp_calls(256'd2)));
    run(256'(XB), 256'd1, 0, 0, calls, late, yv);
    chk("y_e1", yv, 256'd357588);
    chk("calls_e1", 256'(calls), 256'(exp_calls(256'd1)));
    run(256'(XB), 256'd0, 0, 0, calls, l0, yv);
    chk("y_e0", yv, 256'd1);
    chk("calls_e0", 256'(calls), 256'd3);
    ev = (256'd1 << 255) | 256'd1;
    run(256'(XB), ev, 0, 0, calls, lbig, yv);
    chk("y_big", yv, powmod(256'(XB), ev));
    chk("calls_big", 256'(calls), 256'(exp_calls(ev)));
    chk("scan_e3", 256'(l3 - lbig), 256'd254);
    chk("scan_e0", 256'(l0 - lbig), 256'd255);

    lat = 5;
    run(256'(XB), 256'd3, 3, 0, calls, late, yv);
    chk("y_poke", yv, 256'd4767837);
    chk("calls_poke", 256'(calls), 256'd7);

    run(256'(XB), 256'd3, 0, 4, calls, late, yv);
    late = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) late++;
      @(negedge clk);
    end
    chk("late_done", 256'(late), 256'd0);
    chk("late_y", y, 256'd0);
    chk("late_busy", 256'(busy), 256'd0);
    run(256'(XB), 256'd3, 0, 0, calls, late, yv);
    chk("y_after_abort", yv, 256'd4767837);

    for (int r = 0; r < N_RAND; r++) begin
      xv = 256'($urandom_range(N - 1, 0));
      ev = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(xv, ev, 0, 0, calls, late, yv);
      chk("y_rand", yv, powmod(xv, ev));
      chk("calls_rand", 256'(calls), 256'(exp_calls(ev)));
    end

    chk("sb_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
